alu_serial_seq: RTL and testbench

- Parametrised, digit-serial successor to the combinational 64-bit ALU. Supports the same four ops (NOR, XOR, ADD, SUB).
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles, trading latency for area.
- Valid/ready handshake on both sides, plus an accumulate mode that feeds the last delivered result back as operand a.
- Sits between the operand-issue logic and the writeback stage in the datapath.

---
 rtl/alu_serial_seq.sv | 106 ++++++++++
 tb/tb_alu_serial_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: digit-serial NOR/XOR/ADD/SUB ALU with valid/ready handshakes and accumulate.
// WIDTH/DIGIT cycles per result, least significant digit first.
module alu_serial_seq #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT-1:0] da, db, dig;
  logic [DIGIT:0]   sum;
  logic [WIDTH+DIGIT-1:0] cat;
  logic             accept;

  assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign s         = s_q;
  assign cout      = cout_q;

  // SUB is a + ~b + 1; the +1 arrives through the carry seeded at accept.
  assign da  = a_q[DIGIT-1:0];
  assign db  = op_q == 2'b11 ? ~b_q[DIGIT-1:0] : b_q[DIGIT-1:0];
  assign sum = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry_q};
  assign dig = op_q[1] ? sum[DIGIT-1:0] : (op_q[0] ? da ^ db : ~(da | db));
  assign cat = {dig, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    s_d     = s_q;
    cout_d  = cout_q;
    if (accept) begin
      a_d     = acc_sel ? s_q : a;
      b_d     = b;
      op_d    = op;
      carry_d = op == 2'b10 ? cin : op == 2'b11;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      carry_d = op_q[1] & sum[DIGIT];
      res_d   = cat[WIDTH+DIGIT-1:DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        s_d     = cat[WIDTH+DIGIT-1:DIGIT];
        cout_d  = op_q[1] & sum[DIGIT];
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: scoreboard bench for alu_serial_seq with an arithmetic reference model.
module tb_alu_serial_seq;
  localparam int W = 64;
  localparam int N = 8;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 0, rst_n = 0, in_valid = 0, in_ready, cin = 0, acc_sel = 0;
  logic         out_valid, out_ready = 1, cout;
  logic [W-1:0] a = '0, b = '0, s;
  logic [1:0]   op = '0;

  typedef struct {logic [W-1:0] s; logic c; int acc;} exp_t;
  exp_t         q[$];
  int           total = 0, bad = 0, cyc = 0, or_mode = 0;
  logic [W-1:0] model_s = '0, deliv_s = '0;
  logic         deliv_c = 0, prev_ov = 0;

  alu_serial_seq #(.WIDTH(W), .DIGIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .acc_sel(acc_sel),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [W:0] act, logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain modulo arithmetic, returns {cout, s}.
  function automatic logic [W:0] model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci);
    case (o)
      2'd0:    model = {1'b0, ~(x | y)};
      2'd1:    model = {1'b0, x ^ y};
      2'd2:    model = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      default: model = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
    endcase
  endfunction

  task automatic issue(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci, logic acc);
    logic [W:0] e;
    int         n = 0;
    @(negedge clk);
    in_valid = 1; op = o; a = x; b = y; cin = ci; acc_sel = acc;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 0;
      return;
    end
    e = model(o, acc ? model_s : x, y, ci);
    q.push_back('{e[W-1:0], e[W], cyc + 1});
    model_s = e[W-1:0];
    @(posedge clk);
    #1;
    in_valid = 0; op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    cin = 1'($urandom); acc_sel = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 0, 1);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = or_mode == 0 ? 1'b1 : or_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // Monitor: checks result against the queue head, latency on out_valid rise, holds otherwise.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          if (!prev_ov) check("latency", cyc, q[0].acc + N);
          check("result", {cout, s}, {q[0].c, q[0].s});
          if (out_ready) begin
            deliv_s = q[0].s;
            deliv_c = q[0].c;
            void'(q.pop_front());
          end
        end
      end else begin
        check("s_hold", {cout, s}, {deliv_c, deliv_s});
        if (q.size() > 0 && cyc >= q[0].acc) check("in_ready_run", in_ready, 0);
      end
    end
    prev_ov = out_valid;
  end

  initial begin
    int n;
    #12;
    check("rst_s", {cout, s}, 0);
    check("rst_ov", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_in_ready", in_ready, 1);

    issue(2'd2, 1, 1, 0, 0);
    issue(2'd2, ONES, 0, 1, 0);
    issue(2'd3, 0, 1, 0, 0);
    issue(2'd3, 1, 1, 1, 0);
    issue(2'd0, 0, 0, 1, 0);
    issue(2'd1, ONES, 0, 1, 0);
    drain();

    or_mode = 1;
    issue(2'd2, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 1, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    repeat (5) @(negedge clk);
    check("bp_valid_held", out_valid, 1);
    or_mode = 0;
    issue(2'd3, 100, 58, 0, 1);
    drain();

    issue(2'd2, 5, 3, 0, 0);
    issue(2'd2, 64'hffff, 2, 0, 1);
    issue(2'd3, 0, 10, 0, 1);
    drain();

    issue(2'd2, 7, 9, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("abort_s", {cout, s}, 0);
    check("abort_ov", out_valid, 0);
    q.delete();
    model_s = '0; deliv_s = '0; deliv_c = 0; prev_ov = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    check("abort_in_ready", in_ready, 1);
    issue(2'd2, 7, 9, 0, 0);
    drain();

    or_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = i % 7 == 0 ? ONES : {$urandom, $urandom};
      y = i % 5 == 0 ? 0 : {$urandom, $urandom};
      issue(2'($urandom), x, y, 1'($urandom), $urandom_range(0, 3) == 0);
    end
    drain();
    or_mode = 0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
